sdram_rw_scheduler: RTL and testbench

Burst-level scheduler in front of the SDRAM arbiter's write and read paths. It watches the write-FIFO fill level and the read-FIFO fill level and decides when to raise `write_trig` / `read_trig`. It counts the words of each granted burst and generates the row/column/bank address for the next burst. Write and read bursts alternate fairly, and frame boundaries are tracked so that reads never overtake writes.

---
 rtl/sdram_rw_scheduler.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_sdram_rw_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rw_scheduler.sv
// sdram_rw_scheduler: burst-level write/read scheduler for an SDRAM arbiter.
// Raises write/read burst triggers from FIFO fill levels, counts granted
// beats, advances row/column addresses, alternates sides fairly and keeps
// reads from overtaking writes.
// Optional feature macro: PINGPONG_BUFFER_EN (two-bank frame ping-pong).
module sdram_rw_scheduler #(
  parameter int unsigned BURST_LEN      = 8,
  parameter int unsigned COL_W          = 9,
  parameter int unsigned ROW_W          = 13,
  parameter int unsigned ROWS_PER_FRAME = 16,
  parameter int unsigned FIFO_AW        = 9
) (
  input  logic               sysclk_100M,
  input  logic               rst,
  input  logic               enable,
  input  logic [FIFO_AW:0]   wfifo_level,
  input  logic [FIFO_AW:0]   rfifo_level,
  input  logic               write_data_vld,
  input  logic               read_data_vld,
  output logic               write_trig,
  output logic               read_trig,
  output logic [ROW_W-1:0]   wr_row,
  output logic [COL_W-1:0]   wr_col,
  output logic [1:0]         wr_bank,
  output logic [ROW_W-1:0]   rd_row,
  output logic [COL_W-1:0]   rd_col,
  output logic [1:0]         rd_bank,
  output logic               frame_wr_done,
  output logic               frame_rd_done,
  output logic               busy,
  output logic               err
);

  localparam int unsigned LVL_W  = FIFO_AW + 1;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN) + 1;
  localparam logic [LVL_W-1:0]  WR_THR    = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  RD_THR    = LVL_W'((1 << FIFO_AW) - BURST_LEN);
  localparam logic [COL_W-1:0]  COL_STEP  = COL_W'(BURST_LEN);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS_PER_FRAME - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_REQ   = 3'd1,
    S_WR_BURST = 3'd2,
    S_RD_REQ   = 3'd3,
    S_RD_BURST = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_write_trig;
  logic              r_read_trig;
  logic              r_busy;
  logic              w_write_trig_d;
  logic              w_read_trig_d;
  logic              w_busy_d;
  logic [BEAT_W-1:0] r_beat;
  logic              r_last_wr;
  logic              r_err;
  logic [ROW_W-1:0]  r_wr_row;
  logic [COL_W-1:0]  r_wr_col;
  logic [ROW_W-1:0]  r_rd_row;
  logic [COL_W-1:0]  r_rd_col;
  logic              r_frame_wr_done;
  logic              r_frame_rd_done;

  logic              w_wr_elig;
  logic              w_rd_elig;
  logic              w_rd_avail;
  logic              w_beat_last;
  logic              w_wr_fin;
  logic              w_rd_fin;
  logic              w_in_wr;
  logic              w_in_rd;
  logic              w_err_evt;
  logic [COL_W-1:0]  w_wr_col_nxt;
  logic [COL_W-1:0]  w_rd_col_nxt;
  logic              w_wr_col_wrap;
  logic              w_rd_col_wrap;
  logic              w_wr_frame_end;
  logic              w_rd_frame_end;

  assign w_in_wr     = (r_state == S_WR_REQ) || (r_state == S_WR_BURST);
  assign w_in_rd     = (r_state == S_RD_REQ) || (r_state == S_RD_BURST);
  assign w_beat_last = (r_beat == BEAT_LAST);
  assign w_wr_fin    = (r_state == S_WR_BURST) && write_data_vld && w_beat_last;
  assign w_rd_fin    = (r_state == S_RD_BURST) && read_data_vld && w_beat_last;
  assign w_err_evt   = (write_data_vld && !w_in_wr) || (read_data_vld && !w_in_rd);

  assign w_wr_elig   = (wfifo_level >= WR_THR);
  assign w_rd_elig   = (rfifo_level <= RD_THR) && w_rd_avail;

  assign w_wr_col_nxt   = r_wr_col + COL_STEP;
  assign w_rd_col_nxt   = r_rd_col + COL_STEP;
  assign w_wr_col_wrap  = (w_wr_col_nxt == '0);
  assign w_rd_col_wrap  = (w_rd_col_nxt == '0);
  assign w_wr_frame_end = w_wr_fin && w_wr_col_wrap && (r_wr_row == ROW_LAST);
  assign w_rd_frame_end = w_rd_fin && w_rd_col_wrap && (r_rd_row == ROW_LAST);

  // State register plus registered trigger/busy outputs
  always_ff @(posedge sysclk_100M) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_write_trig <= 1'b0;
      r_read_trig  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_write_trig <= w_write_trig_d;
      r_read_trig  <= w_read_trig_d;
      r_busy       <= w_busy_d;
    end
  end

  // Next-state logic: fair arbitration in IDLE, beat-driven burst exit
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          if (w_wr_elig && w_rd_elig) begin
            w_next_state = r_last_wr ? S_RD_REQ : S_WR_REQ;
          end else if (w_wr_elig) begin
            w_next_state = S_WR_REQ;
          end else if (w_rd_elig) begin
            w_next_state = S_RD_REQ;
          end
        end
      end
      S_WR_REQ:   if (write_data_vld) w_next_state = S_WR_BURST;
      S_WR_BURST: if (w_wr_fin)       w_next_state = S_IDLE;
      S_RD_REQ:   if (read_data_vld)  w_next_state = S_RD_BURST;
      S_RD_BURST: if (w_rd_fin)       w_next_state = S_IDLE;
      default:                        w_next_state = S_IDLE;
    endcase
  end

  // Output decode from next state, registered in the state register block
  always_comb begin
    w_write_trig_d = 1'b0;
    w_read_trig_d  = 1'b0;
    w_busy_d       = 1'b0;
    w_write_trig_d = (w_next_state == S_WR_REQ);
    w_read_trig_d  = (w_next_state == S_RD_REQ);
    w_busy_d       = (w_next_state != S_IDLE);
  end

  // Beat counter: first matching word in REQ is beat 1
  always_ff @(posedge sysclk_100M) begin
    if (rst) begin
      r_beat <= '0;
    end else if ((r_state == S_WR_REQ && write_data_vld) ||
                 (r_state == S_RD_REQ && read_data_vld)) begin
      r_beat <= BEAT_W'(1);
    end else if ((r_state == S_WR_BURST && write_data_vld) ||
                 (r_state == S_RD_BURST && read_data_vld)) begin
      r_beat <= w_beat_last ? '0 : r_beat + BEAT_W'(1);
    end
  end

  // Fairness flag and sticky protocol error
  always_ff @(posedge sysclk_100M) begin
    if (rst) begin
      r_last_wr <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_wr_fin) begin
        r_last_wr <= 1'b1;
      end else if (w_rd_fin) begin
        r_last_wr <= 1'b0;
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  // Write address advance and frame-end pulse
  always_ff @(posedge sysclk_100M) begin
    if (rst) begin
      r_wr_col        <= '0;
      r_wr_row        <= '0;
      r_frame_wr_done <= 1'b0;
    end else begin
      r_frame_wr_done <= w_wr_frame_end;
      if (w_wr_fin) begin
        r_wr_col <= w_wr_col_nxt;
        if (w_wr_col_wrap) begin
          r_wr_row <= (r_wr_row == ROW_LAST) ? '0 : r_wr_row + ROW_W'(1);
        end
      end
    end
  end

  // Read address advance and frame-end pulse
  always_ff @(posedge sysclk_100M) begin
    if (rst) begin
      r_rd_col        <= '0;
      r_rd_row        <= '0;
      r_frame_rd_done <= 1'b0;
    end else begin
      r_frame_rd_done <= w_rd_frame_end;
      if (w_rd_fin) begin
        r_rd_col <= w_rd_col_nxt;
        if (w_rd_col_wrap) begin
          r_rd_row <= (r_rd_row == ROW_LAST) ? '0 : r_rd_row + ROW_W'(1);
        end
      end
    end
  end

`ifdef PINGPONG_BUFFER_EN
  logic       r_frame_ready;
  logic [1:0] r_wr_bank;
  logic [1:0] r_rd_bank;
  logic [1:0] r_done_bank;
  logic       w_rd_frame_start;

  // A read frame starts when burst 1 of the frame is requested
  assign w_rd_frame_start = (r_state == S_IDLE) && (w_next_state == S_RD_REQ) &&
                            (r_rd_row == '0) && (r_rd_col == '0);
  assign w_rd_avail = r_frame_ready || (r_rd_row != '0) || (r_rd_col != '0);

  // Bank ping-pong: writers swap banks per frame, readers follow the last full frame
  always_ff @(posedge sysclk_100M) begin
    if (rst) begin
      r_frame_ready <= 1'b0;
      r_wr_bank     <= 2'd0;
      r_rd_bank     <= 2'd0;
      r_done_bank   <= 2'd0;
    end else begin
      if (w_wr_frame_end) begin
        r_wr_bank     <= {1'b0, ~r_wr_bank[0]};
        r_done_bank   <= r_wr_bank;
        r_frame_ready <= 1'b1;
      end else if (w_rd_frame_start) begin
        r_frame_ready <= 1'b0;
      end
      if (w_rd_frame_start) begin
        r_rd_bank <= r_done_bank;
      end
    end
  end

  assign wr_bank = r_wr_bank;
  assign rd_bank = r_rd_bank;
`else
  localparam int unsigned AV_W = ROW_W + COL_W;
  logic [AV_W-1:0] r_avail;

  assign w_rd_avail = (r_avail != '0);

  // Bursts written but not yet read
  always_ff @(posedge sysclk_100M) begin
    if (rst) begin
      r_avail <= '0;
    end else if (w_wr_fin && !w_rd_fin) begin
      r_avail <= r_avail + AV_W'(1);
    end else if (w_rd_fin && !w_wr_fin) begin
      r_avail <= r_avail - AV_W'(1);
    end
  end

  assign wr_bank = 2'd0;
  assign rd_bank = 2'd0;
`endif

  assign write_trig    = r_write_trig;
  assign read_trig     = r_read_trig;
  assign busy          = r_busy;
  assign err           = r_err;
  assign wr_row        = r_wr_row;
  assign wr_col        = r_wr_col;
  assign rd_row        = r_rd_row;
  assign rd_col        = r_rd_col;
  assign frame_wr_done = r_frame_wr_done;
  assign frame_rd_done = r_frame_rd_done;

endmodule

// File: tb/tb_sdram_rw_scheduler.sv
// Testbench for sdram_rw_scheduler: scoreboard of expected burst start
// addresses, pushed when a burst is expected and popped when a trigger rises.
module tb_sdram_rw_scheduler;

  localparam int unsigned BL  = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned RW  = 13;
  localparam int unsigned RPF = 2;
  localparam int unsigned FAW = 9;
  localparam int BPR = (1 << CW) / BL;
  localparam int BPF = BPR * RPF;

  logic           sysclk_100M = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic [FAW:0]   wfifo_level = '0;
  logic [FAW:0]   rfifo_level = '0;
  logic           write_data_vld = 1'b0;
  logic           read_data_vld = 1'b0;
  logic           write_trig;
  logic           read_trig;
  logic [RW-1:0]  wr_row;
  logic [CW-1:0]  wr_col;
  logic [1:0]     wr_bank;
  logic [RW-1:0]  rd_row;
  logic [CW-1:0]  rd_col;
  logic [1:0]     rd_bank;
  logic           frame_wr_done;
  logic           frame_rd_done;
  logic           busy;
  logic           err;

  sdram_rw_scheduler #(
    .BURST_LEN(BL), .COL_W(CW), .ROW_W(RW), .ROWS_PER_FRAME(RPF), .FIFO_AW(FAW)
  ) u_dut (
    .sysclk_100M   (sysclk_100M),
    .rst           (rst),
    .enable        (enable),
    .wfifo_level   (wfifo_level),
    .rfifo_level   (rfifo_level),
    .write_data_vld(write_data_vld),
    .read_data_vld (read_data_vld),
    .write_trig    (write_trig),
    .read_trig     (read_trig),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .wr_bank       (wr_bank),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_bank       (rd_bank),
    .frame_wr_done (frame_wr_done),
    .frame_rd_done (frame_rd_done),
    .busy          (busy),
    .err           (err)
  );

  always #5 sysclk_100M = ~sysclk_100M;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit wr;
    int row;
    int col;
    int bank;
  } exp_t;

  exp_t sb[$];
  int   wr_k = 0;
  int   rd_k = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk_100M);
    #1;
  endtask

  // Expected start address of the k-th burst on one side
  task automatic expect_burst(input bit wr);
    exp_t e;
    int   k;
    k      = wr ? wr_k : rd_k;
    e.wr   = wr;
    e.col  = (k * BL) % (1 << CW);
    e.row  = (k / BPR) % RPF;
`ifdef PINGPONG_BUFFER_EN
    e.bank = (k / BPF) % 2;
`else
    e.bank = 0;
`endif
    sb.push_back(e);
    if (wr) wr_k++;
    else    rd_k++;
  endtask

  task automatic wait_trig(input string tag);
    exp_t e;
    int   i;
    i = 0;
    while (!write_trig && !read_trig && i < 40) begin
      tick();
      i++;
    end
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (!write_trig && !read_trig) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, " dir"}, 32'(write_trig), 32'(e.wr));
    check({tag, " excl"}, 32'(write_trig & read_trig), 32'd0);
    if (e.wr) begin
      check({tag, " wr_row"}, 32'(wr_row), e.row);
      check({tag, " wr_col"}, 32'(wr_col), e.col);
      check({tag, " wr_bank"}, 32'(wr_bank), e.bank);
    end else begin
      check({tag, " rd_row"}, 32'(rd_row), e.row);
      check({tag, " rd_col"}, 32'(rd_col), e.col);
      check({tag, " rd_bank"}, 32'(rd_bank), e.bank);
    end
  endtask

  // n consecutive beats; at beat index err_at also pulse the other side's vld
  task automatic run_beats(input bit wr, input int n, input int err_at);
    for (int i = 0; i < n; i++) begin
      if (wr) write_data_vld = 1'b1;
      else    read_data_vld  = 1'b1;
      if (i == err_at) begin
        if (wr) read_data_vld  = 1'b1;
        else    write_data_vld = 1'b1;
      end
      tick();
      write_data_vld = 1'b0;
      read_data_vld  = 1'b0;
      if (i == 0) check("trig_drop", 32'(wr ? write_trig : read_trig), 32'd0);
    end
  endtask

  task automatic do_burst(input bit wr, input string tag, input int err_at);
    expect_burst(wr);
    wait_trig(tag);
    run_beats(wr, BL, err_at);
    check({tag, " busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      seen = seen | write_trig | read_trig;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b1; wfifo_level = 10'd8; rfifo_level = 10'd0;
    repeat (3) tick();
    check("reset_trig", 32'({write_trig, read_trig}), 32'd0);
    check("reset_busy_err", 32'({busy, err}), 32'd0);
    check("reset_frame", 32'({frame_wr_done, frame_rd_done}), 32'd0);
    check("reset_wr_addr", 32'(wr_row) | 32'(wr_col) | 32'(wr_bank), 32'd0);
    check("reset_rd_addr", 32'(rd_row) | 32'(rd_col) | 32'(rd_bank), 32'd0);
    rst = 1'b0;
    tick();
    check("trig_cycle2", 32'(write_trig), 32'd1);
    check("busy_req", 32'(busy), 32'd1);

`ifdef PINGPONG_BUFFER_EN
    do_burst(1'b1, "w0", -1);
    do_burst(1'b1, "w1", -1);
    do_burst(1'b1, "w2", -1);
    check("pp_bank_mid", 32'(wr_bank), 32'd0);
    do_burst(1'b1, "w3", -1);
    check("pp_frame_wr", 32'(frame_wr_done), 32'd1);
    check("pp_wr_bank", 32'(wr_bank), 32'd1);
    do_burst(1'b0, "r0", -1);
    do_burst(1'b1, "w4", -1);
    check("pp_err", 32'(err), 32'd0);
`else
    do_burst(1'b1, "w0", -1);
    check("w0 wr_col_after", 32'(wr_col), 32'd8);
    check("w0 wr_row_after", 32'(wr_row), 32'd0);
    do_burst(1'b0, "r0", -1);
    check("r0 rd_col_after", 32'(rd_col), 32'd8);
    rfifo_level = 10'd505;
    do_burst(1'b1, "w1", -1);
    check("w1 wr_col_after", 32'(wr_col), 32'd0);
    check("w1 wr_row_after", 32'(wr_row), 32'd1);
    check("w1 no_frame", 32'(frame_wr_done), 32'd0);
    check("err_clean", 32'(err), 32'd0);
    do_burst(1'b1, "w2", 2);
    check("err_set", 32'(err), 32'd1);
    check("w2 wr_col_after", 32'(wr_col), 32'd8);
    do_burst(1'b1, "w3", -1);
    check("w3 frame_wr", 32'(frame_wr_done), 32'd1);
    check("w3 wr_row_wrap", 32'(wr_row), 32'd0);
    check("w3 wr_col_wrap", 32'(wr_col), 32'd0);
    wfifo_level = 10'd7;
    rfifo_level = 10'd504;
    tick();
    check("frame_wr_pulse_end", 32'(frame_wr_done), 32'd0);
    do_burst(1'b0, "r1", -1);
    do_burst(1'b0, "r2", -1);
    check("r2 no_frame", 32'(frame_rd_done), 32'd0);
    do_burst(1'b0, "r3", -1);
    check("r3 frame_rd", 32'(frame_rd_done), 32'd1);
    check("r3 rd_row_wrap", 32'(rd_row), 32'd0);
    expect_quiet("no_avail_quiet", 10);
    enable = 1'b0;
    wfifo_level = 10'd8;
    expect_quiet("enable_low_quiet", 10);
    enable = 1'b1;
    expect_burst(1'b1);
    wait_trig("w4");
    enable = 1'b0;
    repeat (3) tick();
    check("trig_hold_enable_low", 32'(write_trig), 32'd1);
    run_beats(1'b1, BL, -1);
    check("w4 busy_end", 32'(busy), 32'd0);
    expect_quiet("enable_low_after", 8);
    rfifo_level = 10'd505;
    enable = 1'b1;
    expect_burst(1'b1);
    wait_trig("w5");
    run_beats(1'b1, 4, -1);
    write_data_vld = 1'b1;
    rst = 1'b1;
    tick();
    write_data_vld = 1'b0;
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid trig", 32'(write_trig), 32'd0);
    check("rst_mid wr_col", 32'(wr_col), 32'd0);
    check("rst_mid err", 32'(err), 32'd0);
    wr_k = 0;
    rd_k = 0;
    rst = 1'b0;
    do_burst(1'b1, "w_post_rst", -1);
    check("post_rst wr_col", 32'(wr_col), 32'd8);
    check("post_rst err", 32'(err), 32'd0);
`endif
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
